// File: rtl/mem_rd_seq_if.sv
// Burst-read sequencer bus: request/memory/stream signals bundled for mem_rd_seq.
// slave is the sequencer side, master is the requester/memory/sink side.
interface mem_rd_seq_if #(
  parameter int DATAW = 8,
  parameter int ADDRW = 9
);
  logic             i_start;
  logic [ADDRW-1:0] i_base;
  logic [ADDRW:0]   i_len;
  logic [ADDRW-1:0] o_raddr;
  logic             o_ren;
  logic [DATAW-1:0] i_rdata;
  logic [DATAW-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_busy;
  logic             o_done;

  modport slave (
    input  i_start, i_base, i_len, i_rdata, i_ready,
    output o_raddr, o_ren, o_data, o_valid, o_busy, o_done
  );

  modport master (
    output i_start, i_base, i_len, i_rdata, i_ready,
    input  o_raddr, o_ren, o_data, o_valid, o_busy, o_done
  );
endinterface

// File: rtl/mem_rd_seq.sv
// Burst read sequencer: issues reads to a 1-cycle-latency memory and streams the
// words out through a 2-entry FIFO with valid/ready flow control.
module mem_rd_seq #(
  parameter int DATAW = 8,
  parameter int DEPTH = 512,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  mem_rd_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [ADDRW-1:0] addr_cnt, addr_nxt, raddr_q;
  logic [ADDRW:0]   remain;
  logic             inflight;
  logic [DATAW-1:0] fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic [2:0]       occ;
  logic             issue, push, pop, last_pop, zero_start, done_q;

  assign push       = inflight;
  assign pop        = bus.o_valid & bus.i_ready;
  // Occupancy the FIFO will reach once the in-flight word lands, net of this cycle's pop.
  assign occ        = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign last_pop   = (state == DRAIN) && pop && (count == 2'd1) && !inflight;
  assign zero_start = (state == IDLE) && bus.i_start && (bus.i_len == '0);
  assign addr_nxt   = (addr_cnt == ADDRW'(DEPTH - 1)) ? '0 : addr_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start && bus.i_len != '0) state_nxt = RUN;
      RUN:     if (issue && remain == (ADDRW+1)'(1)) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.o_busy  = (state != IDLE);
    issue       = (state == RUN) && (remain != '0) && (occ < 3'd2);
    bus.o_ren   = issue;
    bus.o_raddr = issue ? addr_cnt : raddr_q;
    bus.o_valid = (count != 2'd0);
    bus.o_data  = fifo_mem[rd_ptr];
    bus.o_done  = done_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_cnt <= '0;
      remain   <= '0;
      raddr_q  <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      done_q   <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= last_pop | zero_start;
      if (state == IDLE && bus.i_start) begin
        addr_cnt <= bus.i_base;
        remain   <= bus.i_len;
      end else if (issue) begin
        addr_cnt <= addr_nxt;
        remain   <= remain - 1'b1;
        raddr_q  <= addr_cnt;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.i_rdata;
  end
endmodule

// File: tb/tb_mem_rd_seq.sv
// Randomized bench for mem_rd_seq: queue-based burst model checked every cycle,
// plus directed bursts whose logged traces are pinned to literal values.
module tb_mem_rd_seq;
  localparam int DATAW = 8;
  localparam int DEPTH = 512;
  localparam int ADDRW = 9;

  typedef struct { int c; int v; } ev_t;

  logic clk, rst;
  mem_rd_seq_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();
  mem_rd_seq #(.DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [DATAW-1:0] mem [DEPTH];
  int total = 0, bad = 0;
  int cyc = 0;
  bit chk_en = 0, rst_prev = 1, rdy_mode = 0;

  // model state
  bit busy_m = 0, done_pend = 0, stall_prev = 0, pop_s, busy_old;
  int acc_left = 0, issued = 0, accepted = 0, start_cyc = 0, tmp;
  logic [DATAW-1:0] data_prev;
  int exp_addr[$];
  int exp_data[$];
  ev_t ren_log[$];
  ev_t pop_log[$];
  int done_log[$];

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.i_rdata <= mem[bus.o_raddr];

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    pop_s = 0;
    if (chk_en) begin
      if (!rst_prev)
        chk({bus.o_ren, bus.o_valid, bus.o_busy, bus.o_done, bus.o_raddr} == '0,
            "reset_outs", int'({bus.o_ren, bus.o_valid, bus.o_busy, bus.o_done, bus.o_raddr}), 0);
      chk(bus.o_busy === busy_m, "busy", int'(bus.o_busy), int'(busy_m));
      chk(bus.o_done === done_pend, "done", int'(bus.o_done), int'(done_pend));
      if (bus.o_done) done_log.push_back(cyc);
      if (bus.o_ren) begin
        ren_log.push_back('{cyc, int'(bus.o_raddr)});
        issued++;
        if (exp_addr.size() == 0) chk(1'b0, "unexpected_ren", int'(bus.o_raddr), -1);
        else begin
          tmp = exp_addr.pop_front();
          chk(int'(bus.o_raddr) == tmp, "raddr", int'(bus.o_raddr), tmp);
        end
      end
      pop_s = bus.o_valid && bus.i_ready;
      if (pop_s) begin
        pop_log.push_back('{cyc, int'(bus.o_data)});
        accepted++;
        if (exp_data.size() == 0) chk(1'b0, "unexpected_pop", int'(bus.o_data), -1);
        else begin
          tmp = exp_data.pop_front();
          chk(int'(bus.o_data) == tmp, "data", int'(bus.o_data), tmp);
        end
      end
      if (bus.o_ren) chk(issued - accepted <= 2, "outstanding", issued - accepted, 2);
      if (stall_prev) chk(bus.o_valid && bus.o_data == data_prev, "stall_hold",
                          int'(bus.o_data), int'(data_prev));
      stall_prev = bus.o_valid && !bus.i_ready;
      data_prev  = bus.o_data;
    end
    busy_old  = busy_m;
    done_pend = 0;
    if (!rst) begin
      busy_m = 0; acc_left = 0; issued = 0; accepted = 0; stall_prev = 0;
      exp_addr.delete(); exp_data.delete();
    end else if (chk_en) begin
      if (pop_s && acc_left > 0) begin
        acc_left--;
        if (acc_left == 0) begin busy_m = 0; done_pend = 1; end
      end
      if (bus.i_start && !busy_old) begin
        start_cyc = cyc + 1;
        if (bus.i_len == 0) done_pend = 1;
        else begin
          busy_m = 1;
          acc_left = int'(bus.i_len);
          for (int i = 0; i < int'(bus.i_len); i++) begin
            exp_addr.push_back((int'(bus.i_base) + i) % DEPTH);
            exp_data.push_back(int'(mem[(int'(bus.i_base) + i) % DEPTH]));
          end
        end
      end
    end
    rst_prev = rst;
  end

  initial begin
    bus.i_ready = 1;
    forever begin
      @(posedge clk); #1;
      bus.i_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int b, input int l);
    bus.i_start = 1; bus.i_base = ADDRW'(b); bus.i_len = (ADDRW+1)'(l);
    tick();
    bus.i_start = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin tick(); n++; end while ((bus.o_busy || busy_m) && n < budget);
    chk(n < budget, "timeout", n, budget);
    tick(); tick();
  endtask

  task automatic clear_logs();
    ren_log.delete(); pop_log.delete(); done_log.delete();
  endtask

  initial begin
    rst = 0; bus.i_start = 0; bus.i_base = '0; bus.i_len = '0;
    for (int a = 0; a < DEPTH; a++) mem[a] = DATAW'(a);
    tick(); chk_en = 1;
    tick(); tick();
    rst = 1;
    tick();

    // base 5, len 4, full throughput
    clear_logs(); start(5, 4); wait_idle(100);
    chk(ren_log.size() == 4, "b5_nren", ren_log.size(), 4);
    chk(pop_log.size() == 4, "b5_npop", pop_log.size(), 4);
    if (ren_log.size() == 4 && pop_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk(ren_log[i].v == 5 + i, "b5_addr", ren_log[i].v, 5 + i);
        chk(ren_log[i].c == start_cyc + i, "b5_addr_cyc", ren_log[i].c, start_cyc + i);
        chk(pop_log[i].v == 5 + i, "b5_data", pop_log[i].v, 5 + i);
        chk(pop_log[i].c == start_cyc + 2 + i, "b5_data_cyc", pop_log[i].c, start_cyc + 2 + i);
      end
      chk(done_log.size() == 1, "b5_ndone", done_log.size(), 1);
      if (done_log.size() == 1)
        chk(done_log[0] == pop_log[3].c + 1, "b5_done_cyc", done_log[0], pop_log[3].c + 1);
    end

    // address wrap
    clear_logs(); start(DEPTH - 2, 4); wait_idle(100);
    chk(ren_log.size() == 4, "wrap_nren", ren_log.size(), 4);
    if (ren_log.size() == 4) begin
      chk(ren_log[0].v == 510, "wrap_a0", ren_log[0].v, 510);
      chk(ren_log[1].v == 511, "wrap_a1", ren_log[1].v, 511);
      chk(ren_log[2].v == 0,   "wrap_a2", ren_log[2].v, 0);
      chk(ren_log[3].v == 1,   "wrap_a3", ren_log[3].v, 1);
    end

    // zero length
    clear_logs(); start(33, 0); wait_idle(10);
    chk(ren_log.size() == 0, "len0_nren", ren_log.size(), 0);
    chk(done_log.size() == 1, "len0_ndone", done_log.size(), 1);
    if (done_log.size() == 1) chk(done_log[0] == start_cyc, "len0_done_cyc", done_log[0], start_cyc);

    // start during a burst is ignored
    clear_logs(); start(100, 6); tick(); start(200, 3); wait_idle(100);
    chk(ren_log.size() == 6, "ign_nren", ren_log.size(), 6);
    chk(pop_log.size() == 6, "ign_npop", pop_log.size(), 6);
    chk(done_log.size() == 1, "ign_ndone", done_log.size(), 1);

    // random stalls, len 8
    rdy_mode = 1;
    clear_logs(); start(20, 8); wait_idle(300);
    chk(pop_log.size() == 8, "stall_npop", pop_log.size(), 8);
    for (int i = 0; i < pop_log.size(); i++)
      chk(pop_log[i].v == 20 + i, "stall_data", pop_log[i].v, 20 + i);
    rdy_mode = 0;

    // reset mid-burst
    clear_logs(); start(40, 10);
    for (int n = 0; n < 50 && pop_log.size() < 2; n++) tick();
    chk(pop_log.size() == 2, "abort_reach", pop_log.size(), 2);
    clear_logs();
    rst = 0; tick(); rst = 1;
    repeat (5) tick();
    chk(done_log.size() == 0, "abort_nodone", done_log.size(), 0);
    clear_logs(); start(0, 2); wait_idle(50);
    chk(pop_log.size() == 2, "post_npop", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      chk(pop_log[0].v == 0, "post_d0", pop_log[0].v, 0);
      chk(pop_log[1].v == 1, "post_d1", pop_log[1].v, 1);
    end
    chk(done_log.size() == 1, "post_ndone", done_log.size(), 1);

    // full-depth burst
    clear_logs(); start(7, DEPTH); wait_idle(2000);
    chk(pop_log.size() == DEPTH, "full_npop", pop_log.size(), DEPTH);
    chk(done_log.size() == 1, "full_ndone", done_log.size(), 1);
    if (ren_log.size() == DEPTH) begin
      chk(ren_log[0].v == 7, "full_first", ren_log[0].v, 7);
      chk(ren_log[505].v == 0, "full_wrap", ren_log[505].v, 0);
      chk(ren_log[DEPTH-1].v == 6, "full_last", ren_log[DEPTH-1].v, 6);
    end else chk(1'b0, "full_nren", ren_log.size(), DEPTH);

    // randomized bursts
    for (int it = 0; it < 25; it++) begin
      int b, l;
      for (int a = 0; a < DEPTH; a++) mem[a] = DATAW'($urandom);
      rdy_mode = 1'($urandom_range(0, 1));
      b = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      clear_logs(); start(b, l);
      if (l > 2 && $urandom_range(0, 1)) begin
        tick(); start($urandom_range(0, DEPTH - 1), $urandom_range(1, 5));
      end
      wait_idle(400);
      chk(pop_log.size() == l, "rnd_npop", pop_log.size(), l);
      chk(done_log.size() == 1, "rnd_ndone", done_log.size(), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_rd_seq.md
MEM_RD_SEQ -- requirements
Module: mem_rd_seq

Interface
REQ-001 SHALL have parameter DATAW, default 8, memory word width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, number of memory words.
REQ-003 SHALL have parameter ADDRW, default $clog2(DEPTH), memory address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port i_start  input  1  request a burst read; sampled only in IDLE.
REQ-007 SHALL have port i_base  input  ADDRW  first address of the burst; sampled with i_start.
REQ-008 SHALL have port i_len  input  ADDRW+1  number of words to read, 0..DEPTH; sampled with i_start.
REQ-009 SHALL have port o_raddr  output  ADDRW  read address to the memory.
REQ-010 SHALL have port o_ren  output  1  high in a cycle where o_raddr is an issued burst read.
REQ-011 SHALL have port i_rdata  input  DATAW  memory read data, valid exactly 1 cycle after address.
REQ-012 SHALL have port o_data  output  DATAW  output stream data.
REQ-013 SHALL have port o_valid  output  1  o_data valid.
REQ-014 SHALL have port i_ready  input  1  downstream accepts; transfer when o_valid and i_ready.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port o_done  output  1  single-cycle pulse at burst completion.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN.
REQ-018 IDLE -> RUN on i_start when i_len>0; load address counter = i_base, remaining-issue count = i_len.
REQ-019 IDLE with i_start and i_len==0 SHALL stay IDLE, issue no reads, assert o_done the next cycle.
REQ-020 i_start SHALL be ignored while o_busy is high.
REQ-021 In RUN, a read SHALL issue (o_ren=1, o_raddr=counter) iff remaining>0 and (fifo_count + inflight - pop) < 2, where inflight is 1 if o_ren was high the previous cycle and pop = o_valid & i_ready.
REQ-022 On each issue, the address counter SHALL increment modulo DEPTH (DEPTH-1 wraps to 0) and remaining SHALL decrement.
REQ-023 When o_ren is low, o_raddr SHALL hold its last value.
REQ-024 i_rdata SHALL be captured into a 2-entry FIFO on the edge following each issue cycle; order preserved.
REQ-025 o_valid SHALL equal FIFO non-empty; o_data SHALL equal the FIFO head.
REQ-026 A simultaneous push and pop with a full FIFO SHALL be legal; neither overflow nor data loss SHALL occur under any i_ready pattern.
REQ-027 RUN -> DRAIN on the issue of the last word; DRAIN -> IDLE on acceptance of the last word, with o_done high in the cycle after that acceptance.
REQ-028 With i_ready held high, throughput SHALL be one word per cycle; first o_valid SHALL appear 2 cycles after the cycle in which i_start is sampled.
REQ-029 o_data SHALL be held stable while o_valid is high and i_ready is low.

Reset
REQ-030 While rst is low at a rising edge: state=IDLE, FIFO empty, inflight=0, counters=0, o_raddr=0, o_ren=0, o_valid=0, o_busy=0, o_done=0.
REQ-031 Reset asserted mid-burst SHALL abort the burst, discard in-flight and buffered data, and produce no o_done.

Verification
REQ-032 Memory preloaded with mem[a]=a; start base=5 len=4, i_ready=1 -> o_raddr 5,6,7,8 on consecutive cycles; o_data 5,6,7,8 on 4 consecutive cycles; o_done one cycle after the last transfer.
REQ-033 base=DEPTH-2, len=4 -> addresses DEPTH-2, DEPTH-1, 0, 1 are read in order.
REQ-034 len=8 with i_ready toggling 1,0,0,1,... randomly -> all 8 words delivered in order; at most 2 outstanding; o_data stable when stalled.
REQ-035 len=0 -> no o_ren, o_busy stays 0, o_done pulses once; i_start during a burst -> ignored, burst completes unchanged.
REQ-036 rst low for 1 cycle during word 3 of len=10 -> all outputs at reset values next cycle; a new start base=0 len=2 then yields mem[0], mem[1] only.
REQ-037 len=DEPTH, i_ready=1 -> exactly DEPTH transfers, address wraps once back to base, single o_done.
